// File: rtl/tpm_access_sequencer_if.sv
// Request/response bundle between the three requesting ports, the access
// sequencer and the single-port SRAM macro. The sequencer uses the slave
// view; requesters and the SRAM sit on the master view.
interface tpm_access_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);

   logic              port1_valid;
   logic              port2_valid;
   logic              port3_valid;
   logic              port1_we;
   logic              port2_we;
   logic              port3_we;
   logic [ADDR_W-1:0] port1_addr;
   logic [ADDR_W-1:0] port2_addr;
   logic [ADDR_W-1:0] port3_addr;
   logic [DATA_W-1:0] port1_wdata;
   logic [DATA_W-1:0] port2_wdata;
   logic [DATA_W-1:0] port3_wdata;
   logic [2:0]        port_priority;

   logic              ready;
   logic              halt;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              port1_rvalid;
   logic              port2_rvalid;
   logic              port3_rvalid;
   logic [DATA_W-1:0] port1_rdata;
   logic [DATA_W-1:0] port2_rdata;
   logic [DATA_W-1:0] port3_rdata;

   modport slave (
      input  port1_valid, port2_valid, port3_valid,
      input  port1_we, port2_we, port3_we,
      input  port1_addr, port2_addr, port3_addr,
      input  port1_wdata, port2_wdata, port3_wdata,
      input  port_priority,
      output ready, halt,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output port1_rvalid, port2_rvalid, port3_rvalid,
      output port1_rdata, port2_rdata, port3_rdata
   );

   modport master (
      output port1_valid, port2_valid, port3_valid,
      output port1_we, port2_we, port3_we,
      output port1_addr, port2_addr, port3_addr,
      output port1_wdata, port2_wdata, port3_wdata,
      output port_priority,
      input  ready, halt,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  port1_rvalid, port2_rvalid, port3_rvalid,
      input  port1_rdata, port2_rdata, port3_rdata
   );

endinterface

// File: rtl/tpm_access_sequencer.sv
// Accepts one batch of up to three port requests, issues them to a
// single-port SRAM one per cycle in the order given by the priority captured
// at accept, and returns read data to the originating port two cycles after
// each read is issued. halt freezes the upstream priority FSM while busy.
module tpm_access_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   tpm_access_sequencer_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   localparam logic [2:0] PRIORITY_123 = 3'd0;
   localparam logic [2:0] PRIORITY_132 = 3'd1;
   localparam logic [2:0] PRIORITY_213 = 3'd2;
   localparam logic [2:0] PRIORITY_231 = 3'd3;
   localparam logic [2:0] PRIORITY_312 = 3'd4;
   localparam logic [2:0] PRIORITY_321 = 3'd5;

   // Port service order as three 2-bit port indices, first in [1:0].
   // Encodings 6 and 7 fall back to 1-2-3.
   function automatic logic [5:0] decode_order(input logic [2:0] prio);
      logic [5:0] ord;
      case (prio)
         PRIORITY_123: ord = {2'd2, 2'd1, 2'd0};
         PRIORITY_132: ord = {2'd1, 2'd2, 2'd0};
         PRIORITY_213: ord = {2'd2, 2'd0, 2'd1};
         PRIORITY_231: ord = {2'd0, 2'd2, 2'd1};
         PRIORITY_312: ord = {2'd1, 2'd0, 2'd2};
         PRIORITY_321: ord = {2'd0, 2'd1, 2'd2};
         default:      ord = {2'd2, 2'd1, 2'd0};
      endcase
      return ord;
   endfunction

   // First port in priority order whose mask bit is still set: {hit, index}.
   // Walking from the last slot back to the first lets the earliest win.
   function automatic logic [2:0] pick_next(input logic [2:0] prio,
                                            input logic [2:0] mask);
      logic [5:0] ord;
      logic [1:0] id;
      logic [2:0] res;
      ord = decode_order(prio);
      res = 3'b000;
      for (int i = 2; i >= 0; i--) begin
         id = ord[i*2 +: 2];
         if (mask[id]) res = {1'b1, id};
      end
      return res;
   endfunction

   state_t            state_q, state_d;

   logic [2:0]        req_valid;
   logic [2:0]        req_we;
   logic [ADDR_W-1:0] req_addr  [3];
   logic [DATA_W-1:0] req_wdata [3];

   logic [2:0]        mask_q;
   logic [2:0]        we_q;
   logic [2:0]        prio_q;
   logic [ADDR_W-1:0] addr_q  [3];
   logic [DATA_W-1:0] wdata_q [3];

   logic              mem_we_hold_q;
   logic [ADDR_W-1:0] mem_addr_hold_q;
   logic [DATA_W-1:0] mem_wdata_hold_q;

   logic [2:0]        pick;
   logic              pick_hit;
   logic [1:0]        pick_sel;
   logic [2:0]        pick_onehot;
   logic [2:0]        mask_rest;

   logic              accept;
   logic              issue;
   logic              ready;
   logic              halt;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   logic              rd_vld_p0;
   logic [1:0]        rd_id_p0;
   logic [2:0]        rvalid_p1;
   logic [DATA_W-1:0] rdata_p1 [3];

   // Gather the three request ports into indexable form.
   always_comb begin
      req_valid    = {bus.port3_valid, bus.port2_valid, bus.port1_valid};
      req_we       = {bus.port3_we, bus.port2_we, bus.port1_we};
      req_addr[0]  = bus.port1_addr;
      req_addr[1]  = bus.port2_addr;
      req_addr[2]  = bus.port3_addr;
      req_wdata[0] = bus.port1_wdata;
      req_wdata[1] = bus.port2_wdata;
      req_wdata[2] = bus.port3_wdata;
   end

   assign pick        = pick_next(prio_q, mask_q);
   assign pick_hit    = pick[2];
   assign pick_sel    = pick[1:0];
   assign pick_onehot = 3'b001 << pick_sel;
   assign mask_rest   = mask_q & ~pick_onehot;

   // State register; reset abandons any batch in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state and SRAM drive; the memory bus holds its last issued value
   // whenever no access is made.
   always_comb begin
      state_d   = state_q;
      ready     = 1'b0;
      halt      = 1'b1;
      accept    = 1'b0;
      issue     = 1'b0;
      mem_en    = 1'b0;
      mem_we    = mem_we_hold_q;
      mem_addr  = mem_addr_hold_q;
      mem_wdata = mem_wdata_hold_q;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            halt  = 1'b0;
            if (|req_valid) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (pick_hit) begin
               issue     = 1'b1;
               mem_en    = 1'b1;
               mem_we    = we_q[pick_sel];
               mem_addr  = addr_q[pick_sel];
               mem_wdata = wdata_q[pick_sel];
            end
            if (!pick_hit || mask_rest == 3'b000) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Batch capture at accept; each issue retires one mask bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q <= '0;
         we_q   <= '0;
         prio_q <= '0;
         for (int i = 0; i < 3; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
         end
      end else if (accept) begin
         mask_q <= req_valid;
         we_q   <= req_we;
         prio_q <= bus.port_priority;
         for (int i = 0; i < 3; i++) begin
            addr_q[i]  <= req_addr[i];
            wdata_q[i] <= req_wdata[i];
         end
      end else if (issue) begin
         mask_q <= mask_rest;
      end
   end

   // Remember the last issued access so the SRAM bus stays put when idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_we_hold_q    <= 1'b0;
         mem_addr_hold_q  <= '0;
         mem_wdata_hold_q <= '0;
      end else if (issue) begin
         mem_we_hold_q    <= mem_we;
         mem_addr_hold_q  <= mem_addr;
         mem_wdata_hold_q <= mem_wdata;
      end
   end

   // Stage p0: note which port a read was issued for; the SRAM returns data
   // during the following cycle. Runs independently of the FSM state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_vld_p0 <= 1'b0;
         rd_id_p0  <= 2'd0;
      end else begin
         rd_vld_p0 <= issue && !mem_we;
         if (issue) rd_id_p0 <= pick_sel;
      end
   end

   // Stage p1: capture SRAM data into the originating port and pulse rvalid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rvalid_p1 <= '0;
         for (int i = 0; i < 3; i++) rdata_p1[i] <= '0;
      end else begin
         rvalid_p1 <= '0;
         if (rd_vld_p0) begin
            rvalid_p1[rd_id_p0] <= 1'b1;
            rdata_p1[rd_id_p0]  <= bus.mem_rdata;
         end
      end
   end

   assign bus.ready        = ready;
   assign bus.halt         = halt;
   assign bus.mem_en       = mem_en;
   assign bus.mem_we       = mem_we;
   assign bus.mem_addr     = mem_addr;
   assign bus.mem_wdata    = mem_wdata;
   assign bus.port1_rvalid = rvalid_p1[0];
   assign bus.port2_rvalid = rvalid_p1[1];
   assign bus.port3_rvalid = rvalid_p1[2];
   assign bus.port1_rdata  = rdata_p1[0];
   assign bus.port2_rdata  = rdata_p1[1];
   assign bus.port3_rdata  = rdata_p1[2];

endmodule

// File: tb/tb_tpm_access_sequencer.sv
// Bench for tpm_access_sequencer: a table of single-batch vectors with
// hand-computed issue order and read data, plus hand-written sequences for
// busy-time requests, back-to-back batches and reset mid-batch.
module tb_tpm_access_sequencer;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;

   localparam logic [31:0] DA = 32'hAAAA0001;
   localparam logic [31:0] DB = 32'hBBBB0002;
   localparam logic [31:0] DC = 32'hCCCC0003;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   tpm_access_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   tpm_access_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // SRAM model: write at the edge, read data registered for the next cycle.
   logic [DATA_W-1:0] sram [256];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata      <= sram[bus.mem_addr];
      end
   end

   typedef struct packed {
      logic [2:0]  valid;
      logic [2:0]  we;
      logic [2:0]  prio;
      logic [23:0] addr;   // port i at [i*8 +: 8]
      logic [95:0] wdata;  // port i at [i*32 +: 32]
      logic [3:0]  k;      // expected issue cycles
      logic [5:0]  ord;    // expected port index per slot, slot s at [s*2 +: 2]
      logic [95:0] rdata;  // expected read data per port
   } vec_t;

   vec_t vecs [9];
   int n_checks = 0;
   int n_err = 0;

   function automatic vec_t mk(input logic [2:0] valid, input logic [2:0] we,
                               input logic [2:0] prio,
                               input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3,
                               input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                               input logic [3:0] k,
                               input logic [1:0] o0, input logic [1:0] o1, input logic [1:0] o2,
                               input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3);
      vec_t v;
      v.valid = valid;
      v.we    = we;
      v.prio  = prio;
      v.addr  = {a3, a2, a1};
      v.wdata = {w3, w2, w1};
      v.k     = k;
      v.ord   = {o2, o1, o0};
      v.rdata = {r3, r2, r1};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] rv();
      return {bus.port3_rvalid, bus.port2_rvalid, bus.port1_rvalid};
   endfunction

   function automatic logic [31:0] rdata_of(input logic [1:0] p);
      case (p)
         2'd0:    return bus.port1_rdata;
         2'd1:    return bus.port2_rdata;
         default: return bus.port3_rdata;
      endcase
   endfunction

   task automatic drive_port(input int p, input logic v, input logic we,
                             input logic [7:0] a, input logic [31:0] d);
      case (p)
         0: begin bus.port1_valid = v; bus.port1_we = we; bus.port1_addr = a; bus.port1_wdata = d; end
         1: begin bus.port2_valid = v; bus.port2_we = we; bus.port2_addr = a; bus.port2_wdata = d; end
         default: begin bus.port3_valid = v; bus.port3_we = we; bus.port3_addr = a; bus.port3_wdata = d; end
      endcase
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      while (!bus.ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("wait_ready", 32'(bus.ready), 32'd1);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic [1:0] p;
      logic [2:0] exp_rv;
      string tag;
      wait_ready();
      for (int i = 0; i < 3; i++)
         drive_port(i, v.valid[i], v.we[i], v.addr[i*8 +: 8], v.wdata[i*32 +: 32]);
      bus.port_priority = v.prio;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) drive_port(i, 1'b0, 1'b0, 8'h00, 32'h0);
      bus.port_priority = 3'd0;
      for (int c = 1; c <= int'(v.k) + 3; c++) begin
         @(negedge clk);
         tag = $sformatf("v%0d c%0d", idx, c);
         if (c <= int'(v.k)) begin
            p = v.ord[(c-1)*2 +: 2];
            check({tag, " mem_en"},   32'(bus.mem_en),   32'd1);
            check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(v.addr[p*8 +: 8]));
            check({tag, " mem_we"},   32'(bus.mem_we),   32'(v.we[p]));
            if (v.we[p]) check({tag, " mem_wdata"}, bus.mem_wdata, v.wdata[p*32 +: 32]);
            check({tag, " ready"}, 32'(bus.ready), 32'd0);
            check({tag, " halt"},  32'(bus.halt),  32'd1);
         end else begin
            check({tag, " mem_en"}, 32'(bus.mem_en), 32'd0);
            check({tag, " ready"},  32'(bus.ready),  32'd1);
            check({tag, " halt"},   32'(bus.halt),   32'd0);
         end
         exp_rv = 3'b000;
         p = 2'd0;
         if (c >= 3 && c - 2 <= int'(v.k)) begin
            p = v.ord[(c-3)*2 +: 2];
            if (!v.we[p]) exp_rv[p] = 1'b1;
         end
         check({tag, " rvalid"}, 32'(rv()), 32'(exp_rv));
         if (exp_rv != 3'b000) check({tag, " rdata"}, rdata_of(p), v.rdata[p*32 +: 32]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) sram[i] = '0;
      sram[8'h10] = 32'hDEADBEEF;
      sram[8'h05] = 32'h0BAD0005;
      sram[8'h06] = 32'h0BAD0006;
      sram[8'h09] = 32'h0BAD0009;
      bus.mem_rdata = '0;
      bus.port_priority = 3'd0;
      for (int i = 0; i < 3; i++) drive_port(i, 1'b0, 1'b0, 8'h00, 32'h0);

      //        valid   we      prio  a1     a2     a3     w1     w2     w3     k  order           rdata p1/p2/p3
      vecs[0] = mk(3'b010, 3'b000, 3'd0, 8'h00, 8'h10, 8'h00, 32'h0, 32'h0, 32'h0, 1, 2'd1, 2'd0, 2'd0, 32'h0, 32'hDEADBEEF, 32'h0);
      vecs[1] = mk(3'b111, 3'b111, 3'd4, 8'h01, 8'h02, 8'h03, DA, DB, DC, 3, 2'd2, 2'd0, 2'd1, 32'h0, 32'h0, 32'h0);
      vecs[2] = mk(3'b101, 3'b001, 3'd5, 8'h05, 8'h00, 8'h05, 32'h55, 32'h0, 32'h0, 2, 2'd2, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0BAD0005);
      vecs[3] = mk(3'b101, 3'b001, 3'd0, 8'h06, 8'h00, 8'h06, 32'h55, 32'h0, 32'h0, 2, 2'd0, 2'd2, 2'd0, 32'h0, 32'h0, 32'h55);
      vecs[4] = mk(3'b101, 3'b000, 3'd2, 8'h01, 8'h00, 8'h03, 32'h0, 32'h0, 32'h0, 2, 2'd0, 2'd2, 2'd0, DA, 32'h0, DC);
      vecs[5] = mk(3'b111, 3'b000, 3'd7, 8'h03, 8'h02, 8'h01, 32'h0, 32'h0, 32'h0, 3, 2'd0, 2'd1, 2'd2, DC, DB, DA);
      vecs[6] = mk(3'b111, 3'b000, 3'd3, 8'h01, 8'h02, 8'h03, 32'h0, 32'h0, 32'h0, 3, 2'd1, 2'd2, 2'd0, DA, DB, DC);
      vecs[7] = mk(3'b110, 3'b010, 3'd1, 8'h00, 8'h09, 8'h09, 32'h0, 32'h99, 32'h0, 2, 2'd2, 2'd1, 2'd0, 32'h0, 32'h0, 32'h0BAD0009);
      vecs[8] = mk(3'b110, 3'b010, 3'd6, 8'h00, 8'h09, 8'h09, 32'h0, 32'h77, 32'h0, 2, 2'd1, 2'd2, 2'd0, 32'h0, 32'h0, 32'h77);

      // Reset values
      #12;
      check("rst ready",     32'(bus.ready),       32'd1);
      check("rst halt",      32'(bus.halt),        32'd0);
      check("rst mem_en",    32'(bus.mem_en),      32'd0);
      check("rst mem_we",    32'(bus.mem_we),      32'd0);
      check("rst mem_addr",  32'(bus.mem_addr),    32'd0);
      check("rst mem_wdata", bus.mem_wdata,        32'd0);
      check("rst rvalid",    32'(rv()),            32'd0);
      check("rst rdata1",    bus.port1_rdata,      32'd0);
      check("rst rdata3",    bus.port3_rdata,      32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Port2 raises valid while a port1/port3 batch is in flight
      wait_ready();
      drive_port(0, 1'b1, 1'b0, 8'h01, 32'h0);
      drive_port(2, 1'b1, 1'b0, 8'h03, 32'h0);
      bus.port_priority = 3'd2;
      @(posedge clk);
      #1;
      drive_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
      drive_port(2, 1'b0, 1'b0, 8'h00, 32'h0);
      drive_port(1, 1'b1, 1'b0, 8'h02, 32'h0);
      bus.port_priority = 3'd0;
      @(negedge clk);
      check("busy c1 mem_en",   32'(bus.mem_en),   32'd1);
      check("busy c1 mem_addr", 32'(bus.mem_addr), 32'h01);
      check("busy c1 ready",    32'(bus.ready),    32'd0);
      @(negedge clk);
      check("busy c2 mem_addr", 32'(bus.mem_addr), 32'h03);
      check("busy c2 ready",    32'(bus.ready),    32'd0);
      @(negedge clk);
      check("busy c3 ready",    32'(bus.ready),    32'd1);
      check("busy c3 mem_en",   32'(bus.mem_en),   32'd0);
      check("busy c3 rvalid",   32'(rv()),         32'b001);
      check("busy c3 rdata1",   bus.port1_rdata,   DA);
      @(posedge clk);
      #1;
      drive_port(1, 1'b0, 1'b0, 8'h00, 32'h0);
      @(negedge clk);
      check("busy c4 mem_en",   32'(bus.mem_en),   32'd1);
      check("busy c4 mem_addr", 32'(bus.mem_addr), 32'h02);
      check("busy c4 rvalid",   32'(rv()),         32'b100);
      check("busy c4 rdata3",   bus.port3_rdata,   DC);
      @(negedge clk);
      check("busy c5 mem_en",   32'(bus.mem_en),   32'd0);
      check("busy c5 rvalid",   32'(rv()),         32'b000);
      @(negedge clk);
      check("busy c6 rvalid",   32'(rv()),         32'b010);
      check("busy c6 rdata2",   bus.port2_rdata,   DB);

      // Back-to-back single-read batches on port1 with valid held high
      wait_ready();
      drive_port(0, 1'b1, 1'b0, 8'h02, 32'h0);
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check($sformatf("b2b c%0d mem_en", c), 32'(bus.mem_en),
               32'((c % 2 == 1) && c <= 7));
         check($sformatf("b2b c%0d ready", c), 32'(bus.ready),
               32'((c % 2 == 0) || c >= 9));
         if (c % 2 == 0 && c <= 8)
            check($sformatf("b2b c%0d addr hold", c), 32'(bus.mem_addr), 32'h02);
         check($sformatf("b2b c%0d rvalid", c), 32'(rv()),
               32'((c % 2 == 1) && c >= 3 && c <= 9));
         if ((c % 2 == 1) && c >= 3 && c <= 9)
            check($sformatf("b2b c%0d rdata1", c), bus.port1_rdata, DB);
         if (c == 8) drive_port(0, 1'b0, 1'b0, 8'h00, 32'h0);
      end

      // Reset during the second issue cycle of a three-read batch
      wait_ready();
      drive_port(0, 1'b1, 1'b0, 8'h01, 32'h0);
      drive_port(1, 1'b1, 1'b0, 8'h02, 32'h0);
      drive_port(2, 1'b1, 1'b0, 8'h03, 32'h0);
      bus.port_priority = 3'd0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) drive_port(i, 1'b0, 1'b0, 8'h00, 32'h0);
      @(negedge clk);
      check("rmid c1 mem_en",   32'(bus.mem_en),   32'd1);
      check("rmid c1 mem_addr", 32'(bus.mem_addr), 32'h01);
      @(negedge clk);
      check("rmid c2 mem_en",   32'(bus.mem_en),   32'd1);
      check("rmid c2 mem_addr", 32'(bus.mem_addr), 32'h02);
      reset_n = 1'b0;
      #1;
      check("rmid rst mem_en", 32'(bus.mem_en),  32'd0);
      check("rmid rst ready",  32'(bus.ready),   32'd1);
      check("rmid rst halt",   32'(bus.halt),    32'd0);
      check("rmid rst rdata1", bus.port1_rdata,  32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check($sformatf("rmid post%0d rvalid", c), 32'(rv()),        32'd0);
         check($sformatf("rmid post%0d mem_en", c), 32'(bus.mem_en),  32'd0);
         check($sformatf("rmid post%0d ready", c),  32'(bus.ready),   32'd1);
         check($sformatf("rmid post%0d halt", c),   32'(bus.halt),    32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/tpm_access_sequencer.md
Name: tpm_access_sequencer

Overview:
- Downstream consumer of the 3-bit port_priority produced by the priority FSM.
- Accepts one batch of up to three port requests (read or write) and issues them to the single-port SRAM macro, one access per cycle, in the order given by the captured priority.
- Steers read data back to the originating port.
- Drives halt to the priority FSM while a batch is in flight, so priority only advances on accepted batches.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 32, memory data width.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- portN_valid  in  1  request valid, N=1..3
- portN_we  in  1  1=write, 0=read, N=1..3
- portN_addr  in  ADDR_W  request address, N=1..3
- portN_wdata  in  DATA_W  write data, N=1..3
- port_priority  in  3  current priority encoding from the priority FSM
- ready  out  1  batch accept enable, common to all ports
- halt  out  1  freeze to the priority FSM
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after a read access
- portN_rvalid  out  1  one-cycle read response pulse, N=1..3
- portN_rdata  out  DATA_W  read response data, N=1..3

Behaviour:
- Reset (clk, reset_n, asynchronous, active-low) values:
  - State = IDLE; ready=1; halt=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All portN_rvalid=0, all portN_rdata=0.
  - Batch registers and read-pending tracker cleared.
- Priority encodings (shared_params.vh):
  - PRIORITY_123=0, PRIORITY_132=1, PRIORITY_213=2, PRIORITY_231=3, PRIORITY_312=4, PRIORITY_321=5.
  - Encodings 6 and 7 are decoded as 123.
- Accept (IDLE, ready=1):
  - On a clock edge where any portN_valid=1, latch the valid mask, we/addr/wdata of all three ports, and the pre-update port_priority value; go to ISSUE.
  - A port is accepted iff valid & ready. A port not valid at that edge waits for the next batch.
  - Requesters hold valid and payload stable until accepted.
- ready = (state==IDLE); halt = ~ready. The priority FSM therefore updates exactly at accept edges.
- ISSUE:
  - Each cycle, drive mem_en=1 combinationally from registers (no extra latency) for the next port in priority order whose mask bit is set, then clear that bit. Invalid ports are skipped with no idle cycle.
  - A batch of k valid ports takes exactly k ISSUE cycles.
  - After the last issue cycle, return to IDLE; ready=1 in the following cycle.
  - Example: accept edge E0 → accesses in cycles E0+1..E0+k → ready high in cycle E0+k+1.
- mem_en=0 whenever no access is issued. mem_we/mem_addr/mem_wdata reflect the issued port; they are don't-care when mem_en=0 but are held at their last values.
- Read path:
  - For a read issued in cycle C, record the port ID in a 1-deep pending register.
  - mem_rdata is sampled at the end of C+1.
  - portN_rdata is updated and portN_rvalid pulses high for exactly cycle C+2.
  - The tracker runs independently of state, so reads issued in the last ISSUE cycle complete while IDLE or during the next batch.
  - Back-to-back reads give back-to-back rvalid pulses.
- Writes produce no response.
- portN_rdata holds its last value when rvalid=0.
- Within a batch, accesses to the same address are ordered strictly by priority: a read later in the order sees an earlier write from the same batch.
- Reset mid-batch:
  - Remaining accesses are abandoned and mem_en drops immediately.
  - Pending read responses are discarded (no rvalid).
  - ready=1 after reset release.
- Simultaneous accept and read completion from the previous batch is legal; the two do not interact.

Test Plan:
- Port2 read addr 0x10, priority 123, SRAM holds 0xDEADBEEF → one mem_en cycle at E0+1 with addr 0x10 we=0; port2_rvalid=1 and port2_rdata=0xDEADBEEF in cycle E0+3; ready low only in cycle E0+1.
- All three ports write (addr 1/2/3, data A/B/C), priority 312 → mem writes in order port3, port1, port2 in cycles E0+1..E0+3; halt=1 for those 3 cycles; ready=1 at E0+4; no rvalid.
- Batch with port1 write addr 5 data 0x55, port3 read addr 5, priority 321 → port3 read issued first and returns old data; repeat with priority 123 → port3 returns 0x55.
- Ports 1 and 3 valid, priority 213 → exactly 2 issue cycles, order port1 then port3; port2 asserting valid during busy is not accepted until ready returns and is then served alone.
- Reset asserted during the 2nd issue cycle of a 3-read batch → mem_en=0 immediately, no further rvalid pulses, ready=1 and halt=0 after release.
- Back-to-back single-read batches on port1 (valid held high) → accesses every 2nd cycle; rvalid pulses every 2nd cycle with correct data.
